fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
Sequencing controller for the in-place radix-2 DIT FFT core (32-point default).
- Accepts N input samples over a valid/ready stream and writes them to the sample RAM in bit-reversed order.
- Drives the butterfly unit with address-pair and twiddle-index generation, stage by stage, then streams the results out in natural order.
- Sits between the sample source / result sink and the RAM + butterfly datapath inside top; asserts fft_finish on completion.

Parameters:
N_LOG2, 5, log2 of FFT size N (N = 1<<N_LOG2)
BF_LAT, 3, butterfly pipeline latency in cycles, issue to writeback (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
start  in  1  begin a transform; sampled only in IDLE
in_valid  in  1  input sample available
in_ready  out  1  controller accepts sample this cycle
ram_we  out  1  sample RAM write enable
ram_wsel  out  1  write-data mux: 0 = input sample, 1 = butterfly result
ram_waddr  out  N_LOG2  RAM write address (input load or butterfly A writeback)
ram_waddr_b  out  N_LOG2  second write address (butterfly B writeback)
bf_valid  out  1  butterfly issue strobe
bf_addr_a  out  N_LOG2  butterfly operand A read address
bf_addr_b  out  N_LOG2  butterfly operand B read address
bf_tw_idx  out  N_LOG2-1  twiddle ROM index
rd_addr  out  N_LOG2  unload read address
out_valid  out  1  result on RAM read port valid
out_ready  in  1  sink accepts result
out_last  out  1  marks result N-1
busy  out  1  high in any state except IDLE
fft_finish  out  1  one-cycle pulse at end of transform

Behaviour:
- States: IDLE, LOAD, CALC, DRAIN, UNLOAD, DONE.
- Reset: state=IDLE; all outputs 0; all counters and the writeback delay line cleared. Reset is honoured mid-operation; no RAM write occurs in the cycle after RST.
- IDLE: start=1 -> LOAD next cycle. start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready: ram_we=1, ram_wsel=0, ram_waddr=bitrev(load_cnt), load_cnt++.
  - After the N-th accept -> CALC with stage=0, k=0.
- CALC (stage s, butterfly k=0..N/2-1):
  - One issue per cycle, bf_valid=1.
  - half=1<<s, pos=k&(half-1).
  - bf_addr_a=((k>>s)<<(s+1))+pos, bf_addr_b=bf_addr_a+half.
  - bf_tw_idx=pos<<(N_LOG2-1-s).
  - After k=N/2-1 -> DRAIN.
- Writeback:
  - The a/b addresses pass through a BF_LAT-deep delay line alongside bf_valid.
  - When the delayed valid is set: ram_we=1, ram_wsel=1, ram_waddr / ram_waddr_b = delayed A/B.
- DRAIN:
  - Hold for BF_LAT cycles so all writebacks of stage s land before stage s+1 reads (no RAW hazard).
  - Then, if s<N_LOG2-1: s++, k=0 -> CALC. Otherwise -> UNLOAD.
- Compute time: N_LOG2*(N/2+BF_LAT) cycles; 95 for the defaults.
- UNLOAD:
  - RAM read latency is 1. rd_addr starts at 0 and out_valid rises one cycle after entry.
  - rd_addr advances only when !out_valid or out_ready. Under backpressure rd_addr and data hold stable.
  - out_last=1 with the result for address N-1.
  - Handshake on out_last -> DONE.
- DONE: fft_finish=1 for exactly one cycle -> IDLE. A start in that cycle is ignored; start is only sampled from the following IDLE cycle.
- Counter wrap: load_cnt, k and rd_addr wrap naturally at their width. The state change happens on the terminal count, so a wrap is never observed.

Optional Feature:
FFT_CYCLE_CNT_EN
- Defined:
  - Adds output cycle_cnt (16 bits).
  - Cleared on start acceptance; increments every cycle while busy; saturates at 0xFFFF.
  - Holds its value after fft_finish until the next start; reset clears it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-CALC: assert RST while stage=2 -> next cycle busy=0, ram_we=0, bf_valid=0; no stray writeback over the following BF_LAT cycles.
- Load order: start, then 32 samples with in_valid held high -> ram_waddr sequence 0,16,8,24,4,...,31; transition to CALC after exactly 32 accepts. Repeat with in_valid toggling every other cycle -> same address order, no skipped addresses.
- Addressing, stage 0: bf pairs (0,1),(2,3)...(30,31), all tw_idx=0. Stage 4: pairs (0,16)..(15,31), tw_idx=0..15. Check 16 issues per stage.
- Hazard spacing: no bf_addr of stage s+1 is issued before the last stage-s writeback. Each CALC->CALC gap is 3 cycles. Total bf_valid-high cycles = 80; first issue to last writeback = 95 cycles.
- Unload backpressure: hold out_ready=0 for 5 cycles mid-stream -> rd_addr frozen, out_valid stays 1. Then 32 results in order, out_last on the 32nd, fft_finish pulse 1 cycle later. start during DONE is ignored.
- FFT_CYCLE_CNT_EN defined, sink always ready -> cycle_cnt equals the measured start-to-fft_finish cycle count and holds that value afterward.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for an in-place radix-2 DIT FFT: bit-reversed load, staged butterfly issue
// with delayed writeback, natural-order unload. Define FFT_CYCLE_CNT_EN to add the cycle_cnt output.
module fft_seq_ctrl #(
  parameter int N_LOG2 = 5,
  parameter int BF_LAT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic              ram_wsel,
  output logic [N_LOG2-1:0] ram_waddr,
  output logic [N_LOG2-1:0] ram_waddr_b,
  output logic              bf_valid,
  output logic [N_LOG2-1:0] bf_addr_a,
  output logic [N_LOG2-1:0] bf_addr_b,
  output logic [N_LOG2-2:0] bf_tw_idx,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              fft_finish
`ifdef FFT_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  localparam int SW = $clog2(N_LOG2 + 1);
  localparam int DW = $clog2(BF_LAT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CALC   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state;
  logic [N_LOG2-1:0] load_cnt;
  logic [N_LOG2-2:0] k;
  logic [SW-1:0]     stage;
  logic [DW-1:0]     drain_cnt;
  logic [N_LOG2-1:0] rd_cnt;
  logic              ov_q;

  logic              vld_dly [BF_LAT];
  logic [N_LOG2-1:0] a_dly   [BF_LAT];
  logic [N_LOG2-1:0] b_dly   [BF_LAT];

  logic [N_LOG2-1:0] k_w, half, addr_a;
  logic [N_LOG2-2:0] mask_k, pos_k;
  logic              wb_vld, fire;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  // Address generation: group index k>>s spreads to stride 2*half, pos is the offset within a group.
  always_comb begin
    k_w    = N_LOG2'(k);
    half   = N_LOG2'(1) << stage;
    mask_k = ~({(N_LOG2-1){1'b1}} << stage);
    pos_k  = k & mask_k;
    addr_a = ((k_w >> stage) << (stage + SW'(1))) + N_LOG2'(pos_k);
  end

  assign wb_vld = vld_dly[BF_LAT-1];
  assign fire   = ov_q & out_ready;

  always_comb begin
    busy        = (state != S_IDLE);
    in_ready    = (state == S_LOAD);
    bf_valid    = (state == S_CALC);
    bf_addr_a   = '0;
    bf_addr_b   = '0;
    bf_tw_idx   = '0;
    if (bf_valid) begin
      bf_addr_a = addr_a;
      bf_addr_b = addr_a + half;
      bf_tw_idx = pos_k << (SW'(N_LOG2 - 1) - stage);
    end
    ram_we      = wb_vld | (in_ready & in_valid);
    ram_wsel    = wb_vld;
    ram_waddr   = '0;
    ram_waddr_b = '0;
    if (wb_vld) begin
      ram_waddr   = a_dly[BF_LAT-1];
      ram_waddr_b = b_dly[BF_LAT-1];
    end else if (in_ready) begin
      ram_waddr   = bitrev(load_cnt);
    end
    out_valid   = ov_q;
    out_last    = ov_q && (rd_cnt == '1);
    // rd_addr points at the displayed result so a stalled read keeps the RAM output stable.
    rd_addr     = (state == S_UNLOAD && fire) ? rd_cnt + N_LOG2'(1) : rd_cnt;
    fft_finish  = (state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      k         <= '0;
      stage     <= '0;
      drain_cnt <= '0;
      rd_cnt    <= '0;
      ov_q      <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) begin
        vld_dly[i] <= 1'b0;
        a_dly[i]   <= '0;
        b_dly[i]   <= '0;
      end
    end else begin
      // Writeback delay line: issue -> writeback after BF_LAT cycles
      vld_dly[0] <= bf_valid;
      a_dly[0]   <= bf_addr_a;
      b_dly[0]   <= bf_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_dly[i] <= vld_dly[i-1];
        a_dly[i]   <= a_dly[i-1];
        b_dly[i]   <= b_dly[i-1];
      end
      case (state)
        S_IDLE: if (start) begin
          state    <= S_LOAD;
          load_cnt <= '0;
        end
        S_LOAD: if (in_valid) begin
          load_cnt <= load_cnt + N_LOG2'(1);
          if (load_cnt == '1) begin
            state <= S_CALC;
            stage <= '0;
            k     <= '0;
          end
        end
        S_CALC: begin
          k <= k + 1'b1;
          if (k == '1) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(BF_LAT - 1)) begin
            if (stage == SW'(N_LOG2 - 1)) begin
              state  <= S_UNLOAD;
              rd_cnt <= '0;
              ov_q   <= 1'b0;
            end else begin
              stage <= stage + SW'(1);
              k     <= '0;
              state <= S_CALC;
            end
          end
        end
        S_UNLOAD: begin
          if (!ov_q) begin
            ov_q <= 1'b1;
          end else if (out_ready) begin
            if (rd_cnt == '1) begin
              ov_q  <= 1'b0;
              state <= S_DONE;
            end else begin
              rd_cnt <= rd_cnt + N_LOG2'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_CYCLE_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: load order, butterfly addressing/writeback timing,
// unload with backpressure, reset mid-compute and (with FFT_CYCLE_CNT_EN) the cycle counter.
module tb_fft_seq_ctrl;
  localparam int N_LOG2 = 5;
  localparam int BF_LAT = 3;
  localparam int N      = 1 << N_LOG2;

  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, ram_we, ram_wsel, bf_valid, out_valid, out_last, busy, fft_finish;
  logic [N_LOG2-1:0] ram_waddr, ram_waddr_b, bf_addr_a, bf_addr_b, rd_addr;
  logic [N_LOG2-2:0] bf_tw_idx;
  logic [N_LOG2-1:0] rd_data;
`ifdef FFT_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  fft_seq_ctrl #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .ram_we(ram_we), .ram_wsel(ram_wsel), .ram_waddr(ram_waddr), .ram_waddr_b(ram_waddr_b),
    .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .bf_tw_idx(bf_tw_idx),
    .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy),
`ifdef FFT_CYCLE_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .fft_finish(fft_finish)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model with 1-cycle read latency whose content at address x is x.
  always @(posedge CLK) rd_data <= rd_addr;

  typedef struct { int a; int b; int tw; int stage; int t; } bf_t;
  bf_t iss_q[$];
  bf_t wb_q[$];
  int  ld_q[$];
  int  un_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic int bitrev_n(input int v);
    int r = 0;
    for (int i = 0; i < N_LOG2; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (bf_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bf_valid: got %b want 0", bf_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || fft_finish !== 1'b0) begin
      n_bad++; $display("FAIL reset_out: got v=%b l=%b f=%b want 0 0 0", out_valid, out_last, fft_finish); end
    n_cmp++; if (rd_addr !== '0 || ram_waddr !== '0) begin
      n_bad++; $display("FAIL reset_addr: got rd=%0d wa=%0d want 0 0", rd_addr, ram_waddr); end
`ifdef FFT_CYCLE_CNT_EN
    n_cmp++; if (cycle_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); end
`endif
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_load(input bit toggle);
    int acc = 0;
    int it  = 0;
    int e;
    @(negedge CLK);
    start = 1'b1;
    while (acc < N && it < 200) begin
      @(negedge CLK);
      start    = 1'b0;
      in_valid = toggle ? ((it % 2) == 0) : 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1 at accept %0d", in_ready, acc); end
      if (in_valid) begin
        ld_q.push_back(bitrev_n(acc));
        acc++;
        e = ld_q.pop_front();
        n_cmp++;
        if (ram_we !== 1'b1 || ram_wsel !== 1'b0 || ram_waddr !== N_LOG2'(e)) begin
          n_bad++; $display("FAIL load_addr: got we=%b sel=%b addr=%0d want 1 0 %0d", ram_we, ram_wsel, ram_waddr, e);
        end
      end else begin
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL load_idle_we: got %b want 0", ram_we); end
      end
      it++;
    end
    n_cmp++; if (acc != N) begin n_bad++; $display("FAIL load_timeout: got %0d accepts want %0d", acc, N); end
  endtask

  task automatic test_calc();
    int it = 0, last_stage = -1, last_iss = 0, n_iss = 0, t_first = -1, t_last_wb = 0;
    bf_t e, w;
    for (int s = 0; s < N_LOG2; s++) begin
      int h = 1 << s;
      for (int g = 0; g < N / (2 * h); g++)
        for (int j = 0; j < h; j++) begin
          e.a = g * 2 * h + j; e.b = e.a + h; e.tw = j * (N / (2 * h)); e.stage = s; e.t = 0;
          iss_q.push_back(e);
        end
    end
    while ((iss_q.size() > 0 || wb_q.size() > 0) && it < 400) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      if (it == 0) begin
        n_cmp++; if (in_ready !== 1'b0 || bf_valid !== 1'b1) begin
          n_bad++; $display("FAIL calc_entry: got ready=%b bf_valid=%b want 0 1", in_ready, bf_valid); end
      end
      if (bf_valid === 1'b1) begin
        n_cmp++;
        if (iss_q.size() == 0) begin
          n_bad++; $display("FAIL calc_extra_issue: got issue at cycle %0d want none", cyc);
        end else begin
          e = iss_q.pop_front();
          if (e.a != int'(bf_addr_a) || e.b != int'(bf_addr_b) || e.tw != int'(bf_tw_idx)) begin
            n_bad++; $display("FAIL calc_pair s%0d: got (%0d,%0d,tw%0d) want (%0d,%0d,tw%0d)",
                              e.stage, bf_addr_a, bf_addr_b, bf_tw_idx, e.a, e.b, e.tw);
          end
          if (last_stage >= 0 && e.stage != last_stage) begin
            n_cmp++; if (wb_q.size() != 0) begin
              n_bad++; $display("FAIL calc_hazard: got %0d pending writebacks want 0 at stage %0d", wb_q.size(), e.stage); end
            n_cmp++; if (cyc - last_iss - 1 != BF_LAT) begin
              n_bad++; $display("FAIL calc_gap: got %0d want %0d", cyc - last_iss - 1, BF_LAT); end
          end
          e.t = cyc + BF_LAT;
          wb_q.push_back(e);
          last_stage = e.stage; last_iss = cyc; n_iss++;
          if (t_first < 0) t_first = cyc;
        end
      end
      if (wb_q.size() > 0 && wb_q[0].t == cyc) begin
        w = wb_q.pop_front();
        t_last_wb = cyc;
        n_cmp++;
        if (ram_we !== 1'b1 || ram_wsel !== 1'b1 || int'(ram_waddr) != w.a || int'(ram_waddr_b) != w.b) begin
          n_bad++; $display("FAIL calc_wb: got we=%b sel=%b (%0d,%0d) want 1 1 (%0d,%0d)",
                            ram_we, ram_wsel, ram_waddr, ram_waddr_b, w.a, w.b);
        end
      end else begin
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL calc_stray_we: got %b want 0 at cycle %0d", ram_we, cyc); end
      end
      it++;
    end
    n_cmp++; if (iss_q.size() != 0 || wb_q.size() != 0) begin
      n_bad++; $display("FAIL calc_timeout: got %0d/%0d pending want 0/0", iss_q.size(), wb_q.size());
      iss_q.delete(); wb_q.delete(); end
    n_cmp++; if (n_iss != N_LOG2 * N / 2) begin n_bad++; $display("FAIL calc_issue_count: got %0d want %0d", n_iss, N_LOG2 * N / 2); end
    n_cmp++; if (t_last_wb - t_first + 1 != N_LOG2 * (N / 2 + BF_LAT)) begin
      n_bad++; $display("FAIL calc_span: got %0d want %0d", t_last_wb - t_first + 1, N_LOG2 * (N / 2 + BF_LAT)); end
  endtask

  task automatic test_unload(input int stall_at);
    int it = 0, stall_left = 0, n_hs = 0, e;
    bit done = 0, stalled = 0;
    for (int i = 0; i < N; i++) un_q.push_back(i);
    while (!done && it < 300) begin
      @(negedge CLK);
      if (stall_at >= 0 && n_hs == stall_at && !stalled) begin stall_left = 5; stalled = 1; end
      out_ready = (stall_left == 0);
      #1;
      if (it == 0) begin
        n_cmp++; if (out_valid !== 1'b0 || rd_addr !== '0 || busy !== 1'b1) begin
          n_bad++; $display("FAIL unload_entry: got v=%b rd=%0d busy=%b want 0 0 1", out_valid, rd_addr, busy); end
      end
      if (stall_left > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || rd_addr !== N_LOG2'(n_hs) || rd_data !== N_LOG2'(n_hs)) begin
          n_bad++; $display("FAIL unload_stall: got v=%b rd=%0d data=%0d want 1 %0d %0d", out_valid, rd_addr, rd_data, n_hs, n_hs);
        end
        stall_left--;
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = un_q.pop_front();
        n_cmp++;
        if (rd_data !== N_LOG2'(e) || out_last !== (e == N - 1)) begin
          n_bad++; $display("FAIL unload_data: got data=%0d last=%b want %0d %b", rd_data, out_last, e, e == N - 1);
        end
        n_hs++;
        if (e == N - 1) done = 1;
      end
      it++;
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL unload_timeout: got %0d results want %0d", n_hs, N); un_q.delete(); end
    @(negedge CLK);
    start = 1'b1;
    #1;
    n_cmp++; if (fft_finish !== 1'b1) begin n_bad++; $display("FAIL done_finish: got %b want 1", fft_finish); end
    @(negedge CLK);
    start = 1'b0;
    #1;
    n_cmp++; if (fft_finish !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse: got finish=%b busy=%b want 0 0", fft_finish, busy); end
    @(negedge CLK);
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL done_start_ignored: got busy=%b ready=%b want 0 0", busy, in_ready); end
  endtask

  task automatic test_reset_mid_calc();
    int n_iss = 0, it = 0;
    @(negedge CLK);
    start = 1'b1;
    repeat (N) begin
      @(negedge CLK);
      start = 1'b0; in_valid = 1'b1;
    end
    while (n_iss < 2 * (N / 2) + 3 && it < 200) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      if (bf_valid === 1'b1) n_iss++;
      it++;
    end
    n_cmp++; if (n_iss != 2 * (N / 2) + 3) begin n_bad++; $display("FAIL rst_mid_reach: got %0d issues want %0d", n_iss, 2 * (N / 2) + 3); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || ram_we !== 1'b0 || bf_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_state: got busy=%b we=%b bf=%b want 0 0 0", busy, ram_we, bf_valid); end
    for (int i = 0; i < BF_LAT + 1; i++) begin
      @(negedge CLK);
      #1;
      n_cmp++; if (ram_we !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_stray_wb: got we=%b busy=%b want 0 0 (cycle %0d)", ram_we, busy, i); end
    end
  endtask

`ifdef FFT_CYCLE_CNT_EN
  task automatic test_cycle_cnt();
    int t0, tf = -1, it = 0;
    @(negedge CLK);
    start = 1'b1; t0 = cyc;
    while (tf < 0 && it < 400) begin
      @(negedge CLK);
      start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (fft_finish === 1'b1) tf = cyc;
      it++;
    end
    in_valid = 1'b0;
    n_cmp++; if (tf < 0) begin n_bad++; $display("FAIL cnt_timeout: got no finish want finish"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      n_cmp++; if (int'(cycle_cnt) != tf - t0) begin
        n_bad++; $display("FAIL cycle_cnt_hold: got %0d want %0d", cycle_cnt, tf - t0); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load(1'b0);
    test_calc();
    test_unload(10);
    test_load(1'b1);
    test_calc();
    test_unload(-1);
    test_reset_mid_calc();
`ifdef FFT_CYCLE_CNT_EN
    test_cycle_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
